// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, slot type and helpers for the 7-segment scan controller.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam int MAX_DIGITS = 8;
    localparam int MAX_IDX_W = $clog2(MAX_DIGITS);

    typedef enum logic {S_BLANK, S_SHOW} slot_t;

    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Active-low one-hot anode pattern; all ones when nothing is lit.
    function automatic logic [MAX_DIGITS-1:0] an_decode(input logic en, input logic [MAX_IDX_W-1:0] idx);
        return en ? ~(MAX_DIGITS'(1) << idx) : '1;
    endfunction

endpackage

// File: rtl/dec7seg.sv
// dec7seg: hex nibble to active-low {g,f,e,d,c,b,a} segment pattern.
module dec7seg (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (hex)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed common-anode 7-segment scanner with blanking gap,
// leading-zero suppression and a frame-synchronous double-buffered value.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load,
    input  logic                    lz_en,
    input  logic                    disp_en,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    load_pending,
    output logic                    frame_tick
);

    import seg_pkg::*;

    localparam int CNT_W = width_of(DIV_CYCLES);
    localparam int IDX_W = width_of(NUM_DIGITS);

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] active;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [NUM_DIGITS-1:0]   lz;
    logic [NUM_DIGITS-1:0]   an_nx;
    logic [3:0]              nib;
    logic [6:0]              dec_seg;
    logic                    wrap;
    logic                    boundary;
    logic                    show;
    logic                    zero;
    slot_t                   slot;

    assign wrap     = cnt == CNT_W'(DIV_CYCLES - 1);
    assign boundary = wrap && idx == IDX_W'(NUM_DIGITS - 1);
    assign slot     = (cnt < CNT_W'(BLANK_CYCLES)) ? S_BLANK : S_SHOW;
    assign nib      = active[{idx, 2'b00} +: 4];

    dec7seg u_dec (
        .hex (nib),
        .seg (dec_seg)
    );

    // A digit is suppressed when it and every more-significant nibble are zero; digit 0 always shows.
    always_comb begin
        lz = '0;
        zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            zero = zero && active[4*k +: 4] == 4'h0;
            lz[k] = lz_en && zero;
        end
        show = slot == S_SHOW && disp_en && !lz[idx];
        an_nx = NUM_DIGITS'(an_decode(show, MAX_IDX_W'(idx)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            idx          <= '0;
            active       <= '0;
            shadow       <= '0;
            load_pending <= 1'b0;
            frame_tick   <= 1'b0;
            an           <= '1;
            seg          <= SEG_BLANK;
        end else begin
            cnt        <= wrap ? '0 : cnt + 1'b1;
            frame_tick <= boundary;
            an         <= an_nx;
            seg        <= show ? dec_seg : SEG_BLANK;
            if (wrap)
                idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            // A load landing on the boundary goes straight to the display.
            if (load && boundary) begin
                active       <= value_in;
                shadow       <= value_in;
                load_pending <= 1'b0;
            end else if (load) begin
                shadow       <= value_in;
                load_pending <= 1'b1;
            end else if (boundary && load_pending) begin
                active       <= shadow;
                load_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: position-based reference model checked every cycle, plus directed literal checks.
module tb_seg_scan_ctrl;

    localparam int N = 4;
    localparam int DIV = 8;
    localparam int BLK = 2;
    localparam int FRAME = N * DIV;
    localparam logic [6:0] FONT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] value_in = '0;
    logic        load = 1'b0;
    logic        lz_en = 1'b0;
    logic        disp_en = 1'b1;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        load_pending;
    logic        frame_tick;

    int n_chk = 0;
    int n_fail = 0;

    int          m_pos = 0;
    logic [15:0] m_act = '0;
    logic [15:0] m_sh = '0;
    logic        m_pend = 1'b0;
    logic [3:0]  e_an = 4'hF;
    logic [6:0]  e_seg = 7'h7F;
    logic        e_ft = 1'b0;

    seg_scan_ctrl #(.NUM_DIGITS(N), .DIV_CYCLES(DIV), .BLANK_CYCLES(BLK)) dut (
        .clk          (clk),
        .rst          (rst),
        .value_in     (value_in),
        .load         (load),
        .lz_en        (lz_en),
        .disp_en      (disp_en),
        .seg          (seg),
        .an           (an),
        .load_pending (load_pending),
        .frame_tick   (frame_tick)
    );

    always #5 clk = ~clk;

    // Position p counts cycles since reset release; digit and slot offset follow from it directly.
    function automatic bit lit(input int p, input logic [15:0] act, input logic lz, input logic de);
        int d = (p / DIV) % N;
        if (!de || (p % DIV) < BLK) return 0;
        if (lz && d != 0 && (act >> (4 * d)) == 16'h0) return 0;
        return 1;
    endfunction

    function automatic logic [3:0] f_an(input int p, input logic [15:0] act, input logic lz, input logic de);
        return lit(p, act, lz, de) ? ~(4'b0001 << ((p / DIV) % N)) : 4'hF;
    endfunction

    function automatic logic [6:0] f_seg(input int p, input logic [15:0] act, input logic lz, input logic de);
        logic [3:0] nb = 4'((act >> (4 * ((p / DIV) % N))));
        return lit(p, act, lz, de) ? FONT[nb] : 7'h7F;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pos  <= 0;
            m_act  <= '0;
            m_sh   <= '0;
            m_pend <= 1'b0;
            e_an   <= 4'hF;
            e_seg  <= 7'h7F;
            e_ft   <= 1'b0;
        end else begin
            e_an  <= f_an(m_pos, m_act, lz_en, disp_en);
            e_seg <= f_seg(m_pos, m_act, lz_en, disp_en);
            e_ft  <= (m_pos % FRAME) == FRAME - 1;
            m_pos <= m_pos + 1;
            if (load && (m_pos % FRAME) == FRAME - 1) begin
                m_act  <= value_in;
                m_pend <= 1'b0;
            end else if (load) begin
                m_sh   <= value_in;
                m_pend <= 1'b1;
            end else if ((m_pos % FRAME) == FRAME - 1 && m_pend) begin
                m_act  <= m_sh;
                m_pend <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at pos %0d: got %0h expected %0h", name, m_pos, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("an", 16'(an), 16'(e_an));
        chk("seg", 16'(seg), 16'(e_seg));
        chk("frame_tick", 16'(frame_tick), 16'(e_ft));
        chk("load_pending", 16'(load_pending), 16'(m_pend));
    end

    // Return at the negedge where outputs reflect position p.
    task automatic go_to(input int p);
        int n = 0;
        while (m_pos != p + 1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        n_chk++;
        if (m_pos != p + 1) begin
            n_fail++;
            $display("FAIL go_to %0d: timeout at pos %0d", p, m_pos);
        end
    endtask

    task automatic pulse_load(input logic [15:0] v);
        value_in = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        // load in the first frame, visible from the second
        pulse_load(16'h12AF);
        go_to(5);   chk("s1 pend", 16'(load_pending), 16'h1);
        go_to(31);  chk("s1 ft", 16'(frame_tick), 16'h1); chk("s1 pend clr", 16'(load_pending), 16'h0);
        go_to(32);  chk("s1 blank an", 16'(an), 16'hF); chk("s1 blank seg", 16'(seg), 16'h7F);
        go_to(34);  chk("s1 d0 an", 16'(an), 16'hE); chk("s1 d0 seg", 16'(seg), 16'h0E);
        go_to(42);  chk("s1 d1 an", 16'(an), 16'hD); chk("s1 d1 seg", 16'(seg), 16'h08);
        go_to(51);  chk("s1 d2 an", 16'(an), 16'hB); chk("s1 d2 seg", 16'(seg), 16'h24);
        go_to(63);  chk("s1 d3 an", 16'(an), 16'h7); chk("s1 d3 seg", 16'(seg), 16'h79);
        chk("s2 ft hi", 16'(frame_tick), 16'h1);
        go_to(64);  chk("s2 ft lo", 16'(frame_tick), 16'h0);
        // mid-frame load waits for the boundary
        go_to(70);  pulse_load(16'h1234);
        go_to(74);  chk("s3 old seg", 16'(seg), 16'h08); chk("s3 pend", 16'(load_pending), 16'h1);
        go_to(95);  chk("s3 pend clr", 16'(load_pending), 16'h0);
        go_to(98);  chk("s3 new seg", 16'(seg), 16'h19); chk("s3 new an", 16'(an), 16'hE);
        // load on the boundary bypasses the shadow
        go_to(126); pulse_load(16'h5678);
        go_to(127); chk("s3 bypass pend", 16'(load_pending), 16'h0); chk("s3 bypass ft", 16'(frame_tick), 16'h1);
        go_to(130); chk("s3 bypass seg", 16'(seg), 16'h00);
        // leading-zero blanking
        lz_en = 1'b1;
        pulse_load(16'h0040);
        go_to(162); chk("s4 d0 an", 16'(an), 16'hE); chk("s4 d0 seg", 16'(seg), 16'h40);
        go_to(170); chk("s4 d1 an", 16'(an), 16'hD); chk("s4 d1 seg", 16'(seg), 16'h19);
        go_to(178); chk("s4 d2 an", 16'(an), 16'hF); chk("s4 d2 seg", 16'(seg), 16'h7F);
        go_to(186); chk("s4 d3 an", 16'(an), 16'hF);
        go_to(190); pulse_load(16'h0000);
        go_to(194); chk("s4 zero an", 16'(an), 16'hE); chk("s4 zero seg", 16'(seg), 16'h40);
        go_to(202); chk("s4 zero d1 an", 16'(an), 16'hF);
        lz_en = 1'b0;
        // display disabled for one whole frame
        go_to(223); chk("s6 ft pre", 16'(frame_tick), 16'h1);
        disp_en = 1'b0;
        go_to(230); pulse_load(16'hABCD);
        go_to(234); chk("s6 an off", 16'(an), 16'hF); chk("s6 seg off", 16'(seg), 16'h7F); chk("s6 pend", 16'(load_pending), 16'h1);
        go_to(250); chk("s6 an off2", 16'(an), 16'hF);
        go_to(255); chk("s6 ft", 16'(frame_tick), 16'h1); chk("s6 pend clr", 16'(load_pending), 16'h0);
        disp_en = 1'b1;
        go_to(258); chk("s6 d0 an", 16'(an), 16'hE); chk("s6 d0 seg", 16'(seg), 16'h21);
        // asynchronous reset during digit 2 SHOW with a load pending
        go_to(260); pulse_load(16'h1111);
        go_to(275); chk("s5 pre an", 16'(an), 16'hB); chk("s5 pre seg", 16'(seg), 16'h03); chk("s5 pre pend", 16'(load_pending), 16'h1);
        #2 rst = 1'b1;
        #1;
        chk("s5 async an", 16'(an), 16'hF);
        chk("s5 async seg", 16'(seg), 16'h7F);
        chk("s5 async pend", 16'(load_pending), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        go_to(2);   chk("s5 d0 an", 16'(an), 16'hE); chk("s5 d0 seg", 16'(seg), 16'h40);
        go_to(10);  chk("s5 d1 an", 16'(an), 16'hD); chk("s5 pend", 16'(load_pending), 16'h0);
        go_to(31);  chk("s5 ft", 16'(frame_tick), 16'h1);
        go_to(33);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. It shares a single dec7seg hex decoder across NUM_DIGITS digits: one digit is selected per time slot, its nibble is steered into the decoder, and the matching anode is driven. A blanking gap between slots suppresses ghosting. A double-buffered load interface allows the value to be updated only at frame boundaries.

Parameters:
NUM_DIGITS, 4, number of digits scanned (legal range 2..8)
DIV_CYCLES, 50000, clk cycles per digit slot (legal range >= 4)
BLANK_CYCLES, 500, cycles at the start of each slot with the display dark (legal range 1..DIV_CYCLES-2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
value_in  in  4*NUM_DIGITS  hex value; nibble k drives digit k, digit 0 is rightmost
load  in  1  one-cycle strobe that captures value_in into the shadow buffer
lz_en  in  1  leading-zero blanking enable (level)
disp_en  in  1  global display enable (level); 0 blanks all digits
seg  out  7  active-low segments {g,f,e,d,c,b,a}, straight from the dec7seg encoding
an  out  NUM_DIGITS  active-low anode select, one-hot-low when a digit is lit
load_pending  out  1  shadow holds a value that is not yet displayed
frame_tick  out  1  one-cycle pulse when the digit index wraps to 0

Behaviour:
- Reset (async, rst=1) clears:
  - slot counter, digit index, active and shadow registers, load_pending and frame_tick all go to 0.
  - an goes to all 1s and seg goes to 7'h7F (dark).
  - The effect is immediate, not clock-gated. Reset mid-slot or mid-load discards all state.
- Slot counter:
  - Width is $clog2(DIV_CYCLES).
  - Counts 0..DIV_CYCLES-1, then wraps to 0.
  - On wrap, idx advances (idx+1, or 0 after NUM_DIGITS-1).
- Slot FSM, derived from the counter:
  - BLANK: cnt < BLANK_CYCLES. an=all 1s, seg=7'h7F.
  - SHOW: cnt >= BLANK_CYCLES. an[idx]=0 with all other bits 1; seg = dec7seg(active nibble idx).
- an and seg are registered. The value computed from cnt/idx in cycle t appears at cycle t+1, so every digit gets exactly DIV_CYCLES-BLANK_CYCLES lit cycles.
- frame_tick:
  - Asserted, registered, in the cycle after cnt wraps with idx=NUM_DIGITS-1.
  - Period is NUM_DIGITS*DIV_CYCLES.
- Load and frame-boundary handling:
  - load=1 writes value_in to shadow and sets load_pending.
  - At a frame boundary (the cnt wrap with idx=NUM_DIGITS-1), if load_pending=1, active<=shadow and load_pending is cleared.
  - load coinciding with a frame boundary: value_in bypasses to active directly and load_pending stays 0.
  - Back-to-back loads: the last one before the boundary wins.
- Leading-zero blanking (lz_en=1):
  - Digit k is blanked (SHOW looks like BLANK) if all nibbles k..NUM_DIGITS-1 of active are 0.
  - Digit 0 is never blanked, so a value of 0 displays as a single "0".
- disp_en=0 forces the BLANK outputs. Counter, idx, frame_tick and the load path keep running.
- An active nibble uses all 16 decoder codes (A..F are displayed). No illegal states exist; idx is constrained to < NUM_DIGITS.

Decomposition:
- Package seg_pkg holds:
  - SEG_BLANK = 7'h7F
  - function for the active-low one-hot anode decode
  - clog2-based width constants
- Sub-module: the existing dec7seg, instantiated once, input = mux of active nibble idx.
- The remainder (counter, FSM, buffers, LZ logic) is flat, roughly 150-250 lines.

Test Plan:
All scenarios use NUM_DIGITS=4, DIV_CYCLES=8, BLANK_CYCLES=2.
1. Reset release then load 16'h12AF, wait one frame -> per slot: 2 cycles an=4'hF, seg=7'h7F, then 6 cycles of:
   - an=4'hE, seg=7'h0E (F)
   - an=4'hD, seg=7'h08 (A)
   - an=4'hB, seg=7'h24 (2)
   - an=4'h7, seg=7'h79 (1)
2. Free-run from reset -> frame_tick pulses exactly once every 32 cycles, high for 1 cycle; idx sequence is 0,1,2,3,0.
3. Load 16'h1234 mid-frame -> load_pending=1 until the boundary, display keeps the old value until then; after the boundary it shows 1234 and load_pending=0. Load 16'h5678 on the boundary cycle -> next frame shows 5678 and load_pending never rises.
4. lz_en=1, value 16'h0040 -> digits 3 and 2 stay dark, digit 1 shows seg=7'h19 (4), digit 0 shows 7'h40 (0). Value 16'h0000 -> only digit 0 lit, showing 7'h40.
5. Assert rst asynchronously mid-SHOW of digit 2 with load_pending=1 -> an=4'hF and seg=7'h7F immediately (same cycle, no clock edge); after release: idx=0, load_pending=0, display shows 0000.
6. disp_en=0 for one full frame -> an stays 4'hF throughout; frame_tick still occurs at 32-cycle spacing; a pending load still transfers at the boundary.
